uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Parametrised successor to the fixed 8N1 UART transmitter used on the board.
- Configurable baud divisor, data width, parity and stop bits.
- An internal TX FIFO with a valid/ready write port lets callers queue bytes without watching the line.
- Sits between status/debug logic and the `uarttx` pad, clocked from the internal 12 MHz oscillator.

Parameters:
- CLK_DIV, 1250: clock cycles per bit time (12 MHz / 9600 baud); legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: FIFO entries; power of 2, ≥ 2.

Ports:
- clk, input, 1: system clock.
- resetn, input, 1: asynchronous active-low reset.
- in_data, input, DATA_BITS: word to queue.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: FIFO can accept; a push occurs when in_valid && in_ready at a rising clk edge.
- tx, output, 1: serial line, idle high; registered output.
- busy, output, 1: high while a frame (or break) is on the line.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: queued words not yet popped.

Behaviour:
- **Interface.** One clock, clk. Reset resetn is asynchronous, active-low.
- **Reset values.**
  - tx = 1, busy = 0, in_ready = 1, fifo_level = 0, FSM = IDLE.
  - Bit timer = 0, FIFO pointers = 0.
  - Reset asserted mid-frame forces tx high immediately and flushes the FIFO; the partial frame is abandoned.
- **FIFO.**
  - in_ready = !full, registered from the level. A push is refused when full, even if a pop occurs in the same cycle.
  - The FSM pops only when the registered level is ≥ 1, so a same-cycle push into an empty FIFO plus pop cannot occur.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: when level ≥ 1, pop the head into the shift register, go to START. Transmission begins on the edge after the push edge, so tx goes low one cycle after the write.
  - START: tx = 0 for CLK_DIV cycles.
  - DATA: DATA_BITS bits, LSB first, each CLK_DIV cycles. Shift right at each bit boundary.
  - PARITY: present only if PARITY != 0, one bit time.
    - Even parity: XOR of the data bits.
    - Odd parity: inverted XOR of the data bits.
    - Parity is computed at pop time.
  - STOP: tx = 1 for STOP_BITS × CLK_DIV cycles. At the end:
    - if level ≥ 1, pop and go straight to START (no idle cycle between frames);
    - otherwise go to IDLE.
- **Bit timer.** Loads CLK_DIV-1 on entering each bit and decrements to 0. The bit boundary is where the timer equals 0. The bit counter counts the DATA bits.
- **Frame length.** (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × CLK_DIV cycles, exactly.
- **busy.** High from the cycle tx first goes low until the final stop-bit cycle inclusive. It does not drop between back-to-back frames.
- **Invalid parameters.** Out-of-range values are a configuration error: simulation `$error` at elaboration; synthesis behaviour is undefined.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- **When defined:**
  - Adds input port `send_break` (1 bit) and an FSM state BREAK.
  - In IDLE, `send_break` high takes priority over a non-empty FIFO.
  - tx is held 0 for 2 × frame length cycles, then 1 for one bit time (CLK_DIV), then returns to IDLE.
  - busy is high throughout; the FIFO is untouched and pushes are still accepted.
  - `send_break` outside IDLE is ignored (not latched).
- **When undefined:** no port, no state; behaviour is exactly as above.

Test Plan:
- Hold resetn low 5 cycles → tx = 1, busy = 0, in_ready = 1, fifo_level = 0.
- CLK_DIV = 4, 8N1, push 0x44 ('D') → tx, starting one cycle after the push: 0 ×4, then bits 0,0,1,0,0,0,1,0 each ×4, then 1 ×4. Total 40 cycles; busy high for exactly those 40 cycles; fifo_level returns to 0.
- CLK_DIV = 4, PARITY = 2, push 0x44 → parity bit 0. PARITY = 1 → parity bit 1. STOP_BITS = 2 → stop phase lasts 8 cycles (frame 48 cycles).
- FIFO_DEPTH = 16, in_valid held high with data 0..17 on consecutive cycles:
  - 17 accepted (one popped early);
  - in_ready low on the 18th until the first frame ends;
  - all 18 words emitted in order with no gap between a stop bit and the next start bit;
  - busy never drops.
- Assert resetn mid-DATA of a queued burst → tx = 1 immediately; after release, no further frames are sent and fifo_level = 0.
- With UART_TX_BREAK_EN, CLK_DIV = 4, 8N1, pulse send_break in IDLE with 1 word queued → tx low for 80 cycles, high for 4 cycles, then the queued frame starts.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : FIFO-buffered UART transmitter. The baud divisor, data width,
//            parity and stop bits are set by parameters. Defining the macro
//            UART_TX_BREAK_EN adds a send_break input and a BREAK state.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_DIV    = 1250,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [DATA_BITS-1:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         tx,
    output logic                         busy,
`ifdef UART_TX_BREAK_EN
    input  logic                         send_break,
`endif
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int c_par_bits  = (PARITY != 0) ? 1 : 0;
    localparam int c_frame_len = (1 + DATA_BITS + c_par_bits + STOP_BITS) * CLK_DIV;
    localparam int c_tmr_w     = $clog2(2 * c_frame_len + 1);
    localparam int c_cnt_w     = $clog2(DATA_BITS);

    localparam logic [c_tmr_w-1:0] c_bit_load  = c_tmr_w'(CLK_DIV - 1);
    localparam logic [c_tmr_w-1:0] c_stop_load = c_tmr_w'(STOP_BITS * CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_last_bit  = c_cnt_w'(DATA_BITS - 1);
    localparam logic [c_ptr_w:0]   c_full      = (c_ptr_w + 1)'(FIFO_DEPTH);
`ifdef UART_TX_BREAK_EN
    localparam logic [c_tmr_w-1:0] c_brk_load  = c_tmr_w'(2 * c_frame_len - 1);
`endif

    generate
        if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
            $error("uart_tx_fifo: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_level;
    logic [c_ptr_w:0]     w_level_next;
    logic                 r_in_ready;

    state_t               r_state;
    logic [c_tmr_w-1:0]   r_timer;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_busy;
`ifdef UART_TX_BREAK_EN
    logic                 r_brk_hi;
`endif

    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_break_req;
    logic                 w_head_par;
    logic [DATA_BITS-1:0] w_head;

`ifdef UART_TX_BREAK_EN
    assign w_break_req = send_break;
`else
    assign w_break_req = 1'b0;
`endif

    assign w_push     = in_valid && r_in_ready;
    assign w_bit_end  = (r_timer == '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_par = (PARITY == 1) ? ~(^w_head) : (^w_head);

    // Pops only ever happen from a registered non-zero level, so an entry is
    // never read in the same cycle it is written.
    always_comb begin
        w_pop = 1'b0;
        if (r_level != '0) begin
            case (r_state)
                S_IDLE:  w_pop = !w_break_req;
                S_STOP:  w_pop = w_bit_end;
`ifdef UART_TX_BREAK_EN
                S_BREAK: w_pop = w_bit_end && r_brk_hi;
`endif
                default: w_pop = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level    <= w_level_next;
            r_in_ready <= (w_level_next != c_full);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            r_brk_hi  <= 1'b0;
`endif
        end else begin
            if (!w_bit_end) begin
                r_timer <= r_timer - 1'b1;
            end
            case (r_state)
                S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (w_break_req) begin
                        r_state  <= S_BREAK;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_timer  <= c_brk_load;
                        r_brk_hi <= 1'b0;
                    end
`endif
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                        r_timer   <= c_bit_load;
                        r_bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= c_bit_load;
                        if (r_bit_cnt == c_last_bit) begin
                            if (PARITY != 0) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                                r_timer <= c_stop_load;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                        r_timer <= c_stop_load;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    // Low phase of two frame times, then one bit time of mark.
                    if (w_bit_end) begin
                        if (!r_brk_hi) begin
                            r_tx     <= 1'b1;
                            r_brk_hi <= 1'b1;
                            r_timer  <= c_bit_load;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
            // A pop always launches a new frame, overriding the state's own exit.
            if (w_pop) begin
                r_state <= S_START;
                r_shift <= w_head;
                r_par   <= w_head_par;
                r_tx    <= 1'b0;
                r_busy  <= 1'b1;
                r_timer <= c_bit_load;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_level = r_level;

endmodule
`default_nettype wire
